// File: rtl/ddr3_cmd_pkg.sv
// Shared state encoding, DDR3 command encodings ({CS,RAS,CAS,WE}) and delay
// helpers for the DDR3 power-up initialisation sequencer.
package ddr3_cmd_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [3:0] {
    IDLE,
    RST_HOLD,
    CKE_WAIT,
    XPR_WAIT,
    MRS2,
    MRS3,
    MRS1,
    MRS0,
    MOD_WAIT,
    ZQCL,
    ZQ_WAIT,
    DONE
  } initState_e;

  localparam logic [3:0]  CMD_DESEL = 4'b1111;
  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [3:0]  CMD_MRS   = 4'b0000;
  localparam logic [3:0]  CMD_ZQCL  = 4'b0110;
  localparam logic [14:0] ZQCL_ADDR = 15'h0400;

  // A state lasting cyc cycles loads cyc-1; a zero length is stretched to one cycle.
  function automatic logic [CNT_W-1:0] cycLoad(input int unsigned cyc);
    int unsigned v;
    v = (cyc <= 1) ? 0 : cyc - 1;
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/init_delay_counter.sv
// Single down counter shared by every timed wait of the DDR3 init sequencer.
// expire is high whenever the count has run down to zero.
module init_delay_counter
  import ddr3_cmd_pkg::*;
(
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - CntOne;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up sequencer: reset hold, CKE enable, MR2/MR3/MR1/MR0 loads, then done.
// Define DDR3_INIT_ZQCL_EN to append a ZQCL calibration and tZQinit wait before done.
module ddr3_init_sequencer
  import ddr3_cmd_pkg::*;
#(
  parameter int unsigned T_RESET_CYC  = 40000,
  parameter int unsigned T_CKE_CYC    = 100000,
  parameter int unsigned T_XPR_CYC    = 32,
  parameter int unsigned T_MRD_CYC    = 4,
  parameter int unsigned T_MOD_CYC    = 12,
  parameter int unsigned T_ZQINIT_CYC = 512,
  parameter logic [14:0] MR0_VAL      = 15'h0520,
  parameter logic [14:0] MR1_VAL      = 15'h0004,
  parameter logic [14:0] MR2_VAL      = 15'h0000,
  parameter logic [14:0] MR3_VAL      = 15'h0000
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        init_done,
  output logic        RESET_DRAM,
  output logic        CKE,
  output logic        CS,
  output logic        RAS,
  output logic        CAS,
  output logic        WE,
  output logic [14:0] Addr_out,
  output logic [2:0]  BA_out
);

  localparam int unsigned T_MOD_EFF = (T_MOD_CYC == 0) ? 1 : T_MOD_CYC;
  localparam int unsigned T_ZQ_EFF  = (T_ZQINIT_CYC == 0) ? 1 : T_ZQINIT_CYC;

  // MR0 and ZQCL occupy one cycle each, so their follow-on waits cover the rest.
  localparam logic [CNT_W-1:0] LD_RESET = cycLoad(T_RESET_CYC);
  localparam logic [CNT_W-1:0] LD_CKE   = cycLoad(T_CKE_CYC);
  localparam logic [CNT_W-1:0] LD_XPR   = cycLoad(T_XPR_CYC);
  localparam logic [CNT_W-1:0] LD_MRD   = cycLoad(T_MRD_CYC);
  localparam logic [CNT_W-1:0] LD_MODW  = cycLoad(T_MOD_EFF - 1);
  localparam logic [CNT_W-1:0] LD_ZQW   = cycLoad(T_ZQ_EFF - 1);

`ifdef DDR3_INIT_ZQCL_EN
  localparam initState_e AFTER_MOD = ZQCL;
`else
  localparam initState_e AFTER_MOD = DONE;
`endif

  initState_e       state_q;
  initState_e       state_d;
  logic             cntLoad;
  logic [CNT_W-1:0] cntValue;
  logic             cntExpire;

  init_delay_counter u_delay (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .load   (cntLoad),
    .value  (cntValue),
    .expire (cntExpire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)     state_d = RST_HOLD;
      RST_HOLD: if (cntExpire) state_d = CKE_WAIT;
      CKE_WAIT: if (cntExpire) state_d = XPR_WAIT;
      XPR_WAIT: if (cntExpire) state_d = MRS2;
      MRS2:     if (cntExpire) state_d = MRS3;
      MRS3:     if (cntExpire) state_d = MRS1;
      MRS1:     if (cntExpire) state_d = MRS0;
      MRS0:     if (cntExpire) state_d = (T_MOD_EFF > 1) ? MOD_WAIT : AFTER_MOD;
      MOD_WAIT: if (cntExpire) state_d = AFTER_MOD;
      ZQCL:     if (cntExpire) state_d = (T_ZQ_EFF > 1) ? ZQ_WAIT : DONE;
      ZQ_WAIT:  if (cntExpire) state_d = DONE;
      DONE:     state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  // The counter is reloaded on every state change with the new state's length.
  always_comb begin
    cntLoad  = (state_d != state_q);
    cntValue = '0;
    case (state_d)
      RST_HOLD:         cntValue = LD_RESET;
      CKE_WAIT:         cntValue = LD_CKE;
      XPR_WAIT:         cntValue = LD_XPR;
      MRS2, MRS3, MRS1: cntValue = LD_MRD;
      MOD_WAIT:         cntValue = LD_MODW;
      ZQ_WAIT:          cntValue = LD_ZQW;
      default:          cntValue = '0;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      RESET_DRAM        <= 1'b0;
      CKE               <= 1'b0;
      {CS, RAS, CAS, WE} <= CMD_DESEL;
      Addr_out          <= '0;
      BA_out            <= '0;
      busy              <= 1'b0;
      init_done         <= 1'b0;
    end else begin
      state_q    <= state_d;
      RESET_DRAM <= !(state_d inside {IDLE, RST_HOLD});
      CKE        <= !(state_d inside {IDLE, RST_HOLD, CKE_WAIT});
      busy       <= !(state_d inside {IDLE, DONE});
      init_done  <= (state_d == DONE);
      {CS, RAS, CAS, WE} <= CMD_NOP;
      Addr_out   <= '0;
      BA_out     <= '0;
      // Commands go out only on the entry cycle of their state.
      if (state_d inside {IDLE, RST_HOLD, CKE_WAIT}) begin
        {CS, RAS, CAS, WE} <= CMD_DESEL;
      end else if (cntLoad) begin
        case (state_d)
          MRS2: begin
            {CS, RAS, CAS, WE} <= CMD_MRS;
            Addr_out <= MR2_VAL;
            BA_out   <= 3'd2;
          end
          MRS3: begin
            {CS, RAS, CAS, WE} <= CMD_MRS;
            Addr_out <= MR3_VAL;
            BA_out   <= 3'd3;
          end
          MRS1: begin
            {CS, RAS, CAS, WE} <= CMD_MRS;
            Addr_out <= MR1_VAL;
            BA_out   <= 3'd1;
          end
          MRS0: begin
            {CS, RAS, CAS, WE} <= CMD_MRS;
            Addr_out <= MR0_VAL;
            BA_out   <= 3'd0;
          end
          ZQCL: begin
            {CS, RAS, CAS, WE} <= CMD_ZQCL;
            Addr_out <= ZQCL_ADDR;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Scoreboard bench for ddr3_init_sequencer: stimulus queues expected pin changes,
// a negedge monitor pops one entry per observed change. Honours DDR3_INIT_ZQCL_EN.
module tb_ddr3_init_sequencer;

  localparam logic [14:0] MR0 = 15'h0520;
  localparam logic [14:0] MR1 = 15'h0046;
  localparam logic [14:0] MR2 = 15'h0218;
  localparam logic [14:0] MR3 = 15'h0004;

  // Pin bundle: {RESET_DRAM, CKE, CS, RAS, CAS, WE, Addr, BA, busy, init_done}
  localparam logic [25:0] RSTB  = {1'b0, 1'b0, 4'b1111, 15'd0, 3'd0, 1'b0, 1'b0};
  localparam logic [25:0] HOLDB = {1'b0, 1'b0, 4'b1111, 15'd0, 3'd0, 1'b1, 1'b0};
  localparam logic [25:0] CKEWB = {1'b1, 1'b0, 4'b1111, 15'd0, 3'd0, 1'b1, 1'b0};
  localparam logic [25:0] NOPB  = {1'b1, 1'b1, 4'b0111, 15'd0, 3'd0, 1'b1, 1'b0};
  localparam logic [25:0] DONEB = {1'b1, 1'b1, 4'b0111, 15'd0, 3'd0, 1'b0, 1'b1};

  // Offsets from the CKE rising edge for the 8/10/5/4/12/16 parameter set.
  localparam int unsigned MRS_OFS [4] = '{5, 9, 13, 17};
  localparam logic [14:0] MR_VAL  [4] = '{MR2, MR3, MR1, MR0};
  localparam logic [2:0]  MR_BA   [4] = '{3'd2, 3'd3, 3'd1, 3'd0};
`ifdef DDR3_INIT_ZQCL_EN
  localparam int unsigned DONE_OFS = 45;
`else
  localparam int unsigned DONE_OFS = 29;
`endif

  typedef struct {
    int unsigned when;
    logic [25:0] bits;
  } expEvt_t;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, init_done, RESET_DRAM, CKE, CS, RAS, CAS, WE;
  logic [14:0] Addr_out;
  logic [2:0]  BA_out;
  logic [25:0] curBits;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  expEvt_t     expQ[$];
  logic [25:0] prevBits;
  bit          prevValid = 1'b0;

  ddr3_init_sequencer #(
    .T_RESET_CYC  (8),
    .T_CKE_CYC    (10),
    .T_XPR_CYC    (5),
    .T_MRD_CYC    (4),
    .T_MOD_CYC    (12),
    .T_ZQINIT_CYC (16),
    .MR0_VAL      (MR0),
    .MR1_VAL      (MR1),
    .MR2_VAL      (MR2),
    .MR3_VAL      (MR3)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .init_done  (init_done),
    .RESET_DRAM (RESET_DRAM),
    .CKE        (CKE),
    .CS         (CS),
    .RAS        (RAS),
    .CAS        (CAS),
    .WE         (WE),
    .Addr_out   (Addr_out),
    .BA_out     (BA_out)
  );

  assign curBits = {RESET_DRAM, CKE, CS, RAS, CAS, WE, Addr_out, BA_out, busy, init_done};

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int unsigned gotWhen,
                             input int unsigned wantWhen, input logic [25:0] got,
                             input logic [25:0] want);
    total++;
    if (got !== want || gotWhen != wantWhen) begin
      bad++;
      $display("[TB] FAIL %s: got cyc=%0d pins=%h, want cyc=%0d pins=%h",
               name, gotWhen, got, wantWhen, want);
    end
  endtask

  task automatic checkPins(input string name, input logic [25:0] want);
    total++;
    if (curBits !== want) begin
      bad++;
      $display("[TB] FAIL %s: got pins=%h, want pins=%h", name, curBits, want);
    end
  endtask

  // Monitor: every change of the pin bundle must match the next queued expectation.
  always @(negedge sysclk) begin : monitor
    expEvt_t e;
    if (prevValid && curBits !== prevBits) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_change: got cyc=%0d pins=%h, want no change",
                 cyc, curBits);
      end else begin
        e = expQ.pop_front();
        checkOutput("pin_event", cyc, e.when, curBits, e.bits);
      end
    end
    prevBits  = curBits;
    prevValid = 1'b1;
  end

  task automatic toNeg();
    @(negedge sysclk);
    #1;
  endtask

  task automatic waitCycle(input int unsigned target);
    while (cyc < target) toNeg();
  endtask

  task automatic expectAt(input int unsigned when, input logic [25:0] bits,
                          input int unsigned limit);
    if (when <= limit) expQ.push_back(expEvt_t'{when: when, bits: bits});
  endtask

  // Queue every expected pin change of a sequence accepted on edge s, up to limit.
  task automatic pushSequence(input int unsigned s, input int unsigned limit);
    int unsigned c;
    c = s + 18;
    expectAt(s, HOLDB, limit);
    expectAt(s + 8, CKEWB, limit);
    expectAt(c, NOPB, limit);
    for (int i = 0; i < 4; i++) begin
      expectAt(c + MRS_OFS[i], {2'b11, 4'b0000, MR_VAL[i], MR_BA[i], 2'b10}, limit);
      expectAt(c + MRS_OFS[i] + 1, NOPB, limit);
    end
`ifdef DDR3_INIT_ZQCL_EN
    expectAt(c + 29, {2'b11, 4'b0110, 15'h0400, 3'd0, 2'b10}, limit);
    expectAt(c + 30, NOPB, limit);
`endif
    expectAt(c + DONE_OFS, DONEB, limit);
  endtask

  task automatic applyStimulus(input int unsigned limitRel, output int unsigned s);
    start = 1'b1;
    s = cyc + 1;
    pushSequence(s, s + limitRel);
  endtask

  task automatic doReset(input string name, input int unsigned holdCyc);
    expQ.push_back(expEvt_t'{when: cyc + 1, bits: RSTB});
    rst_n = 1'b0;
    #1;
    checkPins(name, RSTB);
    repeat (holdCyc) toNeg();
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    int unsigned s;
    rst_n = 1'b1;
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkPins("reset_init", RSTB);
    repeat (3) toNeg();
    rst_n = 1'b1;
    waitCycle(cyc + 10);
    checkPins("idle_after_reset", RSTB);

    // Run A: single-cycle start pulse
    toNeg();
    applyStimulus(1000, s);
    toNeg();
    start = 1'b0;
    waitCycle(s + 18 + DONE_OFS + 20);
    checkPins("done_hold_a", DONEB);

    // Run B: start held high through the whole sequence
    doReset("reset_from_done_b", 2);
    toNeg();
    applyStimulus(1000, s);
    waitCycle(s + 18 + DONE_OFS + 20);
    checkPins("done_hold_b", DONEB);
    start = 1'b0;

    // Run C: extra start pulse during XPR_WAIT is ignored
    doReset("reset_from_done_c", 2);
    toNeg();
    applyStimulus(1000, s);
    toNeg();
    start = 1'b0;
    waitCycle(s + 18 + 2);
    start = 1'b1;
    toNeg();
    start = 1'b0;
    waitCycle(s + 18 + DONE_OFS + 20);
    checkPins("done_hold_c", DONEB);

    // Run D: reset asserted while waiting after MR1
    doReset("reset_from_done_d", 2);
    toNeg();
    applyStimulus(18 + 14, s);
    toNeg();
    start = 1'b0;
    waitCycle(s + 18 + 15);
    checkPins("mrs1_wait", NOPB);
    doReset("reset_mid_mrs1", 2);
    waitCycle(cyc + 60);
    checkPins("idle_no_cmd", RSTB);

    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL missing_events: got %0d queued, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr3_init_sequencer.md
DDR3_INIT_SEQUENCER -- requirements
Module: ddr3_init_sequencer

Interface
REQ-001 SHALL have parameter T_RESET_CYC, default 40000; cycles RESET_DRAM held low (200 us at 5 ns).
REQ-002 SHALL have parameter T_CKE_CYC, default 100000; cycles from RESET_DRAM high to CKE high (500 us).
REQ-003 SHALL have parameter T_XPR_CYC, default 32; cycles from CKE high to first MRS.
REQ-004 SHALL have parameters T_MRD_CYC, default 4, and T_MOD_CYC, default 12; command-to-command spacing after MRS and after MR0.
REQ-005 SHALL have parameter T_ZQINIT_CYC, default 512; cycles from ZQCL to init_done.
REQ-006 SHALL have parameters MR0_VAL, MR1_VAL, MR2_VAL, MR3_VAL, 15 bits each, defaults 15'h0520, 15'h0004, 15'h0000, 15'h0000.
REQ-007 SHALL have port sysclk, input, 1, the single clock for all flops.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, begins the sequence when sampled high in IDLE.
REQ-010 SHALL have port busy, output, 1, high from the cycle after start is accepted until init_done.
REQ-011 SHALL have port init_done, output, 1, sticky high once the sequence completes.
REQ-012 SHALL have ports RESET_DRAM, CKE, CS, RAS, CAS, WE, output, 1 each; DRAM pins, commands active-low.
REQ-013 SHALL have ports Addr_out, output, 15, and BA_out, output, 3; the command address and bank.

Function
REQ-014 SHALL implement states IDLE, RST_HOLD, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MRS0, MOD_WAIT, ZQCL, ZQ_WAIT, DONE.
REQ-015 SHALL move IDLE->RST_HOLD on the edge sampling start=1; start SHALL be ignored in every other state.
REQ-016 SHALL hold RESET_DRAM=0, CKE=0 for exactly T_RESET_CYC cycles in RST_HOLD, then RESET_DRAM=1 for T_CKE_CYC cycles with CKE=0 in CKE_WAIT.
REQ-017 SHALL assert CKE=1 on entry to XPR_WAIT and keep it high thereafter; NOP (CS=0,RAS=1,CAS=1,WE=1) on every non-command cycle while CKE=1.
REQ-018 SHALL issue MRS (CS=RAS=CAS=WE=0) for one cycle each in the order MR2 (BA=2), MR3 (BA=3), MR1 (BA=1), MR0 (BA=0), with Addr_out=MRn_VAL, first MRS exactly T_XPR_CYC cycles after CKE rises.
REQ-019 SHALL space consecutive MRS commands exactly T_MRD_CYC cycles apart (the command cycle counts as cycle 1).
REQ-020 SHALL issue the next command exactly T_MOD_CYC cycles after MR0.
REQ-021 SHALL drive Addr_out=0 and BA_out=0 on all NOP cycles.
REQ-022 SHALL use a single down counter loaded on each state entry; any timing parameter value of 0 SHALL be treated as 1.
REQ-023 SHALL in DONE hold init_done=1, busy=0, CKE=1, RESET_DRAM=1, NOP, until rst_n asserts.

Reset
REQ-024 SHALL on rst_n=0, at any time including mid-sequence, immediately force state IDLE, RESET_DRAM=0, CKE=0, CS=1, RAS=1, CAS=1, WE=1, Addr_out=0, BA_out=0, busy=0, init_done=0, counter=0.
REQ-025 SHALL remain in IDLE after rst_n deasserts until start is sampled high.

Configuration
REQ-026 SHALL, with macro DDR3_INIT_ZQCL_EN defined, issue ZQCL (CS=0,RAS=1,CAS=1,WE=0, Addr_out[10]=1) T_MOD_CYC cycles after MR0 and assert init_done T_ZQINIT_CYC cycles after ZQCL.
REQ-027 SHALL, without DDR3_INIT_ZQCL_EN, omit ZQCL/ZQ_WAIT and assert init_done T_MOD_CYC cycles after MR0.

Structure
REQ-028 SHALL take state encodings and command encodings (NOP, MRS, ZQCL as {CS,RAS,CAS,WE}) from shared package ddr3_cmd_pkg.
REQ-029 SHALL instantiate one sub-module, init_delay_counter (load, value, expire), for all waits.

Verification
REQ-030 SHALL cover: params 8/10/5/4/12/16, start pulse 1 cycle -> RESET_DRAM low 8 cycles, then high with CKE low 10 cycles, then CKE high.
REQ-031 SHALL cover: same run -> MRS at CKE+5, +9, +13, +17 with BA 2,3,1,0 and Addr_out MR2,MR3,MR1,MR0 values.
REQ-032 SHALL cover: ZQCL_EN defined -> ZQCL 12 cycles after MR0 with Addr_out[10]=1, init_done 16 cycles later; undefined -> init_done 12 cycles after MR0.
REQ-033 SHALL cover: rst_n pulsed low during MRS1 wait -> all outputs at reset values same cycle, no further commands until new start.
REQ-034 SHALL cover: start held high continuously and pulsed during XPR_WAIT -> exactly one sequence, identical timing to REQ-030/031.
